bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_seq.sv | 150 +++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to binary converter: one multiply-by-10 accumulate per cycle.
// Optional invalid-digit detection is compiled in with BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [9:0] bin,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_H = 2'd1,
        ACC_T = 2'd2,
        ACC_O = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [9:0]  acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [9:0]  bin_q, bin_d;

    logic [3:0]  digit_sel;
    logic [13:0] mac_w;
    logic        unused_mac_hi;

    // acc*10 + digit as shift-and-add; upper bits are dropped (result is mod 1024).
    assign digit_sel     = (state_q == ACC_O) ? ones_q : tens_q;
    assign mac_w         = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {10'b0, digit_sel};
    assign unused_mac_hi = ^mac_w[13:10];

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic [3:0] digit_in [3];
    logic [2:0] digit_bad;
    logic       inv_q, inv_d;
    logic       err_q, err_d;

    assign digit_in[0] = hundreds;
    assign digit_in[1] = tens;
    assign digit_in[2] = ones;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (digit_in[gi] > 4'd9);
        end
    endgenerate
`endif

    always_comb begin
        state_d = state_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        inv_d   = inv_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    hund_d  = hundreds;
                    tens_d  = tens;
                    ones_d  = ones;
                    acc_d   = 10'd0;
                    busy_d  = 1'b1;
                    state_d = ACC_H;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    inv_d   = |digit_bad;
`endif
                end
            end
            ACC_H: begin
                acc_d   = {6'b0, hund_q};
                state_d = ACC_T;
            end
            ACC_T: begin
                acc_d   = mac_w[9:0];
                state_d = ACC_O;
            end
            ACC_O: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                bin_d   = inv_q ? 10'd0 : mac_w[9:0];
                err_d   = inv_q;
`else
                bin_d   = mac_w[9:0];
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            acc_q   <= 10'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: expected results are queued at start and
// compared when done pulses; handshake timing is checked at fixed cycle offsets.
module tb_bcd_to_bin_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [9:0] bin;
    logic       err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int dones  = 0;

    logic [9:0] exp_bin_q [$];
    logic       exp_err_q [$];
    logic [9:0] last_bin;
    logic       last_err;

    bcd_to_bin_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done),
        .bin      (bin),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: decimal value of the digits, with optional invalid-digit handling.
    task automatic push_expect(input int h, input int t, input int o);
        int   v;
        logic e;
        v = (100 * h + 10 * t + o) % 1024;
        e = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (h > 9 || t > 9 || o > 9) begin
            v = 0;
            e = 1'b1;
        end
`endif
        exp_bin_q.push_back(v[9:0]);
        exp_err_q.push_back(e);
        last_bin = v[9:0];
        last_err = e;
        $display("queue  digits %0d,%0d,%0d -> bin=%0d err=%0d", h, t, o, v, e);
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            dones++;
            check("done_expected", 32'(exp_bin_q.size() != 0), 32'd1);
            if (exp_bin_q.size() != 0) begin
                logic [9:0] eb;
                logic       ee;
                eb = exp_bin_q.pop_front();
                ee = exp_err_q.pop_front();
                $display("done   bin=%0d err=%0d (expected %0d/%0d)", bin, err, eb, ee);
                check("bin", 32'(bin), 32'(eb));
                check("err", 32'(err), 32'(ee));
            end
        end
    end

    // One conversion with a one-cycle start pulse; digits scrambled after E0.
    task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        start = 1'b1; hundreds = h; tens = t; ones = o;
        push_expect(int'(h), int'(t), int'(o));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hundreds = 4'($urandom_range(0, 15));
        tens     = 4'($urandom_range(0, 15));
        ones     = 4'($urandom_range(0, 15));
        check("busy_e0", 32'(busy), 32'd1);
        check("done_e0", 32'(done), 32'd0);
        @(negedge clk);
        check("busy_e1", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_e2", 32'(busy), 32'd1);
        check("done_e2", 32'(done), 32'd0);
        @(negedge clk);
        check("busy_e3", 32'(busy), 32'd0);
        check("done_e3", 32'(done), 32'd1);
        @(negedge clk);
        check("done_e4", 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
        last_bin = 10'd0; last_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bin",  32'(bin),  32'd0);
        check("rst_err",  32'(err),  32'd0);
        rst_n = 1'b1;

        run_conv(4'd1, 4'd2, 4'd3);
        run_conv(4'd9, 4'd9, 4'd9);
        run_conv(4'd0, 4'd0, 4'd0);

        // Restart attempt at E1 with new digits must be ignored.
        d0 = dones;
        @(negedge clk);
        start = 1'b1; hundreds = 4'd4; tens = 4'd5; ones = 4'd6;
        push_expect(4, 5, 6);
        @(posedge clk);
        @(negedge clk);
        hundreds = 4'd7; tens = 4'd7; ones = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("ignored_restart_dones", 32'(dones - d0), 32'd1);
        check("ignored_restart_busy", 32'(busy), 32'd0);

        // start held high: conversions accepted at E0, E4, E8.
        d0 = dones;
        @(negedge clk);
        start = 1'b1; hundreds = 4'd0; tens = 4'd4; ones = 4'd2;
        for (int k = 0; k < 3; k++) push_expect(0, 4, 2);
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("held_done", 32'(done), 32'((k % 4) == 3));
            if (k == 8) start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("held_dones", 32'(dones - d0), 32'd3);
        check("held_bin_hold", 32'(bin), 32'd42);

        // Asynchronous reset mid-conversion aborts it without a done pulse.
        d0 = dones;
        @(negedge clk);
        start = 1'b1; hundreds = 4'd3; tens = 4'd1; ones = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bin",  32'(bin),  32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_conv(4'd0, 4'd0, 4'd7);
        check("abort_dones", 32'(dones - d0), 32'd1);

        // Invalid tens digit.
        run_conv(4'd1, 4'hA, 4'd0);
        repeat (3) @(negedge clk);
        check("final_bin_hold", 32'(bin), 32'(last_bin));
        check("final_err_hold", 32'(err), 32'(last_err));
        check("queue_empty", 32'(exp_bin_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
